// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel-rate enable into the generator and the
// coordinate, sync, blank and frame outputs going to the drawing stages.
interface vga_timing_if;
    logic        pixel_en;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        visible;
    logic        hsync;
    logic        vsync;
    logic        startOfFrame;
    logic [7:0]  frameCount;
    logic        hsync_d;
    logic        vsync_d;
    logic        blank_d;

    modport master (
        input  pixel_en,
        output pixelX, pixelY, visible, hsync, vsync, startOfFrame,
               frameCount, hsync_d, vsync_d, blank_d
    );

    modport slave (
        output pixel_en,
        input  pixelX, pixelY, visible, hsync, vsync, startOfFrame,
               frameCount, hsync_d, vsync_d, blank_d
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 raster timing generator: pixel counters, sync/visible decode,
// frame strobe/counter and a pixel_en-clocked delay line for sync and blank.
module vga_timing_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 1
) (
    input logic         clk,
    input logic         reset,
    vga_timing_if.master vif
);
    localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    // Delay-stage reset image: both syncs inactive, blank asserted.
    localparam logic [2:0]  PIPE_RST = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b1};

    logic [10:0] x_reg, x_next;
    logic [10:0] y_reg, y_next;
    logic [7:0]  frame_cnt_reg, frame_cnt_next;
    logic        visible_reg, visible_next;
    logic        hsync_reg, hsync_next;
    logic        vsync_reg, vsync_next;
    logic        sof_reg;
    logic        h_wrap, v_wrap, frame_wrap;
    logic [2:0]  pipe_src;
    logic [2:0]  pipe_out;

    always_comb begin
        h_wrap         = (x_reg == H_LAST);
        v_wrap         = (y_reg == V_LAST);
        frame_wrap     = h_wrap && v_wrap;
        x_next         = h_wrap ? 11'd0 : x_reg + 11'd1;
        y_next         = y_reg;
        if (h_wrap) begin
            y_next = v_wrap ? 11'd0 : y_reg + 11'd1;
        end
        frame_cnt_next = frame_wrap ? frame_cnt_reg + 8'd1 : frame_cnt_reg;
        // Decode from the next counts so the flags line up with the new coordinates.
        visible_next   = (x_next < H_VIS) && (y_next < V_VIS);
        hsync_next     = (x_next >= HS_START && x_next < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next     = (y_next >= VS_START && y_next < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg         <= 11'd0;
            y_reg         <= 11'd0;
            frame_cnt_reg <= 8'd0;
            visible_reg   <= 1'b1;
            hsync_reg     <= ~SYNC_ACTIVE;
            vsync_reg     <= ~SYNC_ACTIVE;
            sof_reg       <= 1'b0;
        end else begin
            // One clk wide regardless of pixel_en duty: cleared on the very next edge.
            sof_reg <= vif.pixel_en && frame_wrap;
            if (vif.pixel_en) begin
                x_reg         <= x_next;
                y_reg         <= y_next;
                frame_cnt_reg <= frame_cnt_next;
                visible_reg   <= visible_next;
                hsync_reg     <= hsync_next;
                vsync_reg     <= vsync_next;
            end
        end
    end

    assign pipe_src = {hsync_reg, vsync_reg, ~visible_reg};

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign pipe_out = pipe_src;
        end else begin : g_delay
            for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
                logic [2:0] d_in;
                logic [2:0] q_reg;
                if (gi == 0) begin : g_head
                    assign d_in = pipe_src;
                end else begin : g_tail
                    assign d_in = g_stage[gi-1].q_reg;
                end
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        q_reg <= PIPE_RST;
                    end else if (vif.pixel_en) begin
                        q_reg <= d_in;
                    end
                end
            end
            assign pipe_out = g_stage[PIPE_DELAY-1].q_reg;
        end
    endgenerate

    assign vif.pixelX       = x_reg;
    assign vif.pixelY       = y_reg;
    assign vif.visible      = visible_reg;
    assign vif.hsync        = hsync_reg;
    assign vif.vsync        = vsync_reg;
    assign vif.startOfFrame = sof_reg;
    assign vif.frameCount   = frame_cnt_reg;
    assign vif.hsync_d      = pipe_out[2];
    assign vif.vsync_d      = pipe_out[1];
    assign vif.blank_d      = pipe_out[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing with delays 1 and 2,
// plus a tiny raster for frame wraps) checked each cycle against a count-based model.
module tb_vga_timing_gen;
    typedef struct {
        int   hv, hf, hs, hb, vv, vf, vs, vb, d;
        logic sa;
    } cfg_t;

    typedef struct {
        int          n;
        logic [10:0] x, y;
        logic        vis, hs, hd1, hd2, bd2;
    } vec_t;

    localparam int SM_FT = 8 * 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic pen   = 1'b0;
    int   n     = 0;
    logic sof_c_exp = 1'b0;
    int   total = 0;
    int   bad   = 0;

    cfg_t cfg_a, cfg_b, cfg_c;
    vec_t tbl [17];

    always #5 clk = ~clk;

    vga_timing_if if_a ();
    vga_timing_if if_b ();
    vga_timing_if if_c ();
    assign if_a.pixel_en = pen;
    assign if_b.pixel_en = pen;
    assign if_c.pixel_en = pen;

    vga_timing_gen #(.PIPE_DELAY(1)) dut_a (.clk(clk), .reset(reset), .vif(if_a));
    vga_timing_gen #(.PIPE_DELAY(2)) dut_b (.clk(clk), .reset(reset), .vif(if_b));
    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE(1'b1), .PIPE_DELAY(0)
    ) dut_c (.clk(clk), .reset(reset), .vif(if_c));

    logic [36:0] got_a, got_b, got_c;
    assign got_a = {if_a.pixelX, if_a.pixelY, if_a.visible, if_a.hsync, if_a.vsync,
                    if_a.startOfFrame, if_a.frameCount, if_a.hsync_d, if_a.vsync_d, if_a.blank_d};
    assign got_b = {if_b.pixelX, if_b.pixelY, if_b.visible, if_b.hsync, if_b.vsync,
                    if_b.startOfFrame, if_b.frameCount, if_b.hsync_d, if_b.vsync_d, if_b.blank_d};
    assign got_c = {if_c.pixelX, if_c.pixelY, if_c.visible, if_c.hsync, if_c.vsync,
                    if_c.startOfFrame, if_c.frameCount, if_c.hsync_d, if_c.vsync_d, if_c.blank_d};

    // {hsync, vsync, blank} of the raster position reached after n pixel strobes.
    function automatic logic [2:0] raster_bits(input cfg_t c, input int cnt);
        int ht, vt, x, y;
        logic hs_l, vs_l, bl_l;
        ht   = c.hv + c.hf + c.hs + c.hb;
        vt   = c.vv + c.vf + c.vs + c.vb;
        x    = cnt % ht;
        y    = (cnt / ht) % vt;
        hs_l = (x >= c.hv + c.hf && x < c.hv + c.hf + c.hs) ? c.sa : ~c.sa;
        vs_l = (y >= c.vv + c.vf && y < c.vv + c.vf + c.vs) ? c.sa : ~c.sa;
        bl_l = !(x < c.hv && y < c.vv);
        return {hs_l, vs_l, bl_l};
    endfunction

    function automatic logic [36:0] expect_vec(input cfg_t c, input int cnt, input logic sof);
        int ht, vt, x, y, fc;
        logic [2:0] now, dl;
        ht  = c.hv + c.hf + c.hs + c.hb;
        vt  = c.vv + c.vf + c.vs + c.vb;
        x   = cnt % ht;
        y   = (cnt / ht) % vt;
        fc  = (cnt / (ht * vt)) % 256;
        now = raster_bits(c, cnt);
        if (cnt >= c.d) dl = raster_bits(c, cnt - c.d);
        else            dl = {~c.sa, ~c.sa, 1'b1};
        return {11'(x), 11'(y), ~now[0], now[2], now[1], sof, 8'(fc), dl};
    endfunction

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (n=%0d)", name, got, exp, n);
            if (bad >= 100) finish_run();
        end
    endtask

    task automatic check_model();
        check("model_a", 64'(got_a), 64'(expect_vec(cfg_a, n, 1'b0)));
        check("model_b", 64'(got_b), 64'(expect_vec(cfg_b, n, 1'b0)));
        check("model_c", 64'(got_c), 64'(expect_vec(cfg_c, n, sof_c_exp)));
    endtask

    // One clk: drive pixel_en, advance the strobe count at the edge, compare at negedge.
    task automatic tick(input logic p);
        pen = p;
        @(posedge clk);
        if (!reset && p) begin
            n++;
            sof_c_exp = (n % SM_FT == 0);
        end else begin
            sof_c_exp = 1'b0;
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic async_reset_pulse();
        reset = 1'b1;
        #1;
        n = 0;
        sof_c_exp = 1'b0;
        check_model();
        tick(1'b1);
        reset = 1'b0;
    endtask

    initial begin
        cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0};
        cfg_b = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
        cfg_c = '{4, 1, 2, 1, 3, 1, 1, 1, 0, 1'b1};
        //            n    x       y      vis hs hd1 hd2 bd2
        tbl[0]  = '{  1, 11'd1,   11'd0, 1, 1, 1, 1, 1};
        tbl[1]  = '{  2, 11'd2,   11'd0, 1, 1, 1, 1, 0};
        tbl[2]  = '{639, 11'd639, 11'd0, 1, 1, 1, 1, 0};
        tbl[3]  = '{640, 11'd640, 11'd0, 0, 1, 1, 1, 0};
        tbl[4]  = '{641, 11'd641, 11'd0, 0, 1, 1, 1, 0};
        tbl[5]  = '{642, 11'd642, 11'd0, 0, 1, 1, 1, 1};
        tbl[6]  = '{655, 11'd655, 11'd0, 0, 1, 1, 1, 1};
        tbl[7]  = '{656, 11'd656, 11'd0, 0, 0, 1, 1, 1};
        tbl[8]  = '{657, 11'd657, 11'd0, 0, 0, 0, 1, 1};
        tbl[9]  = '{658, 11'd658, 11'd0, 0, 0, 0, 0, 1};
        tbl[10] = '{751, 11'd751, 11'd0, 0, 0, 0, 0, 1};
        tbl[11] = '{752, 11'd752, 11'd0, 0, 1, 0, 0, 1};
        tbl[12] = '{753, 11'd753, 11'd0, 0, 1, 1, 0, 1};
        tbl[13] = '{754, 11'd754, 11'd0, 0, 1, 1, 1, 1};
        tbl[14] = '{799, 11'd799, 11'd0, 0, 1, 1, 1, 1};
        tbl[15] = '{800, 11'd0,   11'd1, 1, 1, 1, 1, 1};
        tbl[16] = '{802, 11'd2,   11'd1, 1, 1, 1, 1, 0};

        // Reset held for 10 clk with pixel_en high: everything stays at reset values.
        #2 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            check("rst_x", 64'(if_a.pixelX), 64'd0);
            check("rst_sof", 64'(if_c.startOfFrame), 64'd0);
        end
        check("rst_vis", 64'(if_a.visible), 64'd1);
        check("rst_hs", 64'(if_a.hsync), 64'd1);
        check("rst_vs", 64'(if_a.vsync), 64'd1);
        check("rst_blank_d", 64'(if_b.blank_d), 64'd1);
        reset = 1'b0;
        tick(1'b1);
        check("rel_x", 64'(if_a.pixelX), 64'd1);

        // One full line with pixel_en tied high, checked at fixed strobe counts.
        for (int i = 0; i < 17; i++) begin
            while (n < tbl[i].n) tick(1'b1);
            check($sformatf("tbl%0d_x", i), 64'(if_a.pixelX), 64'(tbl[i].x));
            check($sformatf("tbl%0d_y", i), 64'(if_a.pixelY), 64'(tbl[i].y));
            check($sformatf("tbl%0d_vis", i), 64'(if_a.visible), 64'(tbl[i].vis));
            check($sformatf("tbl%0d_hs", i), 64'(if_a.hsync), 64'(tbl[i].hs));
            check($sformatf("tbl%0d_hs_d1", i), 64'(if_a.hsync_d), 64'(tbl[i].hd1));
            check($sformatf("tbl%0d_hs_d2", i), 64'(if_b.hsync_d), 64'(tbl[i].hd2));
            check($sformatf("tbl%0d_blank_d2", i), 64'(if_b.blank_d), 64'(tbl[i].bd2));
        end

        // Frame wrap on the small raster with pixel_en toggling 1-of-2.
        async_reset_pulse();
        while (n < SM_FT - 1) tick(1'b1);
        check("pre_wrap_x", 64'(if_c.pixelX), 64'd7);
        check("pre_wrap_y", 64'(if_c.pixelY), 64'd5);
        tick(1'b0);
        check("hold_x", 64'(if_c.pixelX), 64'd7);
        check("hold_sof", 64'(if_c.startOfFrame), 64'd0);
        tick(1'b1);
        check("wrap_x", 64'(if_c.pixelX), 64'd0);
        check("wrap_y", 64'(if_c.pixelY), 64'd0);
        check("wrap_sof", 64'(if_c.startOfFrame), 64'd1);
        check("wrap_fc", 64'(if_c.frameCount), 64'd1);
        tick(1'b0);
        check("wrap_sof_clr", 64'(if_c.startOfFrame), 64'd0);
        check("wrap_hold_x", 64'(if_c.pixelX), 64'd0);
        tick(1'b1);
        check("after_x", 64'(if_c.pixelX), 64'd1);
        check("after_sof", 64'(if_c.startOfFrame), 64'd0);

        // Random pixel_en pattern, long enough to wrap the small frame counter.
        for (int i = 0; i < 20000; i++) tick($urandom_range(0, 3) != 0);

        // Mid-frame reset: outputs must clear before any clk edge.
        while ((n % SM_FT) < 20) tick(1'b1);
        reset = 1'b1;
        #1;
        check("arst_x_a", 64'(if_a.pixelX), 64'd0);
        check("arst_y_a", 64'(if_a.pixelY), 64'd0);
        check("arst_x_c", 64'(if_c.pixelX), 64'd0);
        check("arst_y_c", 64'(if_c.pixelY), 64'd0);
        check("arst_fc_c", 64'(if_c.frameCount), 64'd0);
        check("arst_vis", 64'(if_a.visible), 64'd1);
        check("arst_hs_c", 64'(if_c.hsync), 64'd0);
        check("arst_blank_d", 64'(if_b.blank_d), 64'd1);
        n = 0;
        sof_c_exp = 1'b0;
        check_model();
        tick(1'b1);
        reset = 1'b0;
        tick(1'b1);
        check("post_arst_x", 64'(if_c.pixelX), 64'd1);
        while (n < SM_FT) tick(1'b1);
        check("post_arst_sof", 64'(if_c.startOfFrame), 64'd1);
        check("post_arst_fc", 64'(if_c.frameCount), 64'd1);
        tick(1'b1);

        finish_run();
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 VGA path. Driven by the system clock and a pixel-rate enable, it produces the pixelX/pixelY coordinates consumed by the background drawer and the object drawers. It also produces the horizontal and vertical sync, visible-area and frame-start strobes, plus copies of sync and blank delayed to align with the registered RGB coming back from the drawing stages.

## Interface

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, active level of hsync/vsync and their delayed copies
- PIPE_DELAY, 1, delay of the *_d outputs in pixel_en strobes; legal range 0..4

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_en  in  1  pixel-rate clock enable; counters advance only when high
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- visible  out  1  high when pixelX<H_VISIBLE and pixelY<V_VISIBLE
- hsync  out  1  horizontal sync, aligned with pixelX
- vsync  out  1  vertical sync, aligned with pixelY
- startOfFrame  out  1  single-clk pulse on frame wrap
- frameCount  out  8  frames completed, modulo 256
- hsync_d, vsync_d  out  1  hsync/vsync delayed by PIPE_DELAY pixel_en strobes
- blank_d  out  1  !visible delayed by PIPE_DELAY pixel_en strobes

## Operation

- Totals:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK, 800 by default.
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK, 525 by default.
  - All arithmetic is unsigned, 11 bits.
- Horizontal counter:
  - On pixel_en, pixelX increments.
  - At H_TOTAL-1 it wraps to 0 and vertical advance is requested.
- Vertical counter:
  - Increments only on a horizontal wrap.
  - At V_TOTAL-1 it wraps to 0 together with pixelX.
  - The frame wrap increments frameCount, modulo 256.
- Sync decode:
  - hsync = SYNC_ACTIVE while H_VISIBLE+H_FRONT <= pixelX < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default); otherwise ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE while V_VISIBLE+V_FRONT <= pixelY < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default); otherwise ~SYNC_ACTIVE.
- visible, hsync and vsync are registered. They are decoded from the next-count values so they are valid in the same clk cycle as the pixelX/pixelY they describe.
- startOfFrame:
  - High for exactly one clk cycle: the first cycle in which pixelX=pixelY=0 after a frame wrap.
  - Its width is independent of the pixel_en duty cycle.
  - Not asserted on release from reset.
- Delay line:
  - A PIPE_DELAY-deep shift register of {hsync, vsync, !visible}, shifting only on pixel_en.
  - PIPE_DELAY=0 makes the *_d outputs equal their undelayed sources.
- pixel_en low: every counter and the delay line hold; startOfFrame stays low.

## Timing

- Reset values:
  - pixelX=0, pixelY=0, frameCount=0.
  - visible=1, which is the decode of (0,0).
  - hsync=vsync=~SYNC_ACTIVE, startOfFrame=0.
  - All delay stages hold hsync_d=vsync_d=~SYNC_ACTIVE and blank_d=1.
- Reset asserted mid-frame forces the reset values immediately, without waiting for a clk edge. The first pixel_en after release moves pixelX to 1.
- Latency:
  - pixelX/pixelY update on the clk edge where pixel_en=1.
  - visible/hsync/vsync change on that same edge.
  - *_d outputs lag their sources by exactly PIPE_DELAY pixel_en strobes.
- With pixel_en tied high: the line period is 800 clk and the frame period is 420000 clk.
- Simultaneous horizontal and vertical wrap (799,524) -> (0,0) on one pixel_en. startOfFrame and the frameCount increment occur on that same edge.
- Line and frame counts are fixed by parameters. No runtime reconfiguration.

## Test plan

- Reset, then hold reset for 10 clk with pixel_en=1 -> pixelX=0, pixelY=0, visible=1, hsync=vsync=1, blank_d=1, startOfFrame never high; after release, pixelX reads 1 after the first pixel_en.
- pixel_en=1 continuously for one line -> hsync falls at the edge where pixelX becomes 656 and rises where pixelX becomes 752; visible falls where pixelX becomes 640; pixelX wraps 799->0 and pixelY goes 0->1.
- Run to (799,524) and apply one pixel_en -> pixelX=pixelY=0, startOfFrame high for 1 clk, frameCount 0->1; vsync low only for pixelY 490..491.
- pixel_en toggling 1-of-2 clk across the frame wrap -> counters advance every other clk; startOfFrame is high for 1 clk, not 2; counters hold when pixel_en=0.
- PIPE_DELAY=2 with pixel_en tied high -> hsync_d falls 2 clk after hsync (pixelX=658); blank_d rises 2 clk after visible falls.
- Assert reset at pixelX=700, pixelY=300 for one cycle -> all outputs return to their reset values asynchronously; the next frame starts cleanly from (0,0) with frameCount=0.
